// File: rtl/adv7393_axil_csr_if.sv
`default_nettype none
// ============================================================================
// Module      : adv7393_axil_csr_if
// Description : AXI4-Lite bus bundle between the PS interconnect (master) and
//               the ADV7393 configuration CSR file (slave).
//               Ports / members:
//                 aw*  : awvalid, awready, awaddr[AWIDTH], awprot[3]
//                 w*   : wvalid, wready, wdata[DWIDTH], wstrb[DWIDTH/8]
//                 b*   : bvalid, bready, bresp[2]
//                 ar*  : arvalid, arready, araddr[AWIDTH], arprot[3]
//                 r*   : rvalid, rready, rdata[DWIDTH], rresp[2]
//               Modports: master (interconnect side), slave (CSR side).
// Revision    : 1.0 - initial release
// ============================================================================
interface adv7393_axil_csr_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [AWIDTH-1:0]     awaddr;
   logic [2:0]            awprot;

   logic                  wvalid;
   logic                  wready;
   logic [DWIDTH-1:0]     wdata;
   logic [DWIDTH/8-1:0]   wstrb;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   logic                  arvalid;
   logic                  arready;
   logic [AWIDTH-1:0]     araddr;
   logic [2:0]            arprot;

   logic                  rvalid;
   logic                  rready;
   logic [DWIDTH-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface
`default_nettype wire

// File: rtl/adv7393_axil_csr.sv
`default_nettype none
// ============================================================================
// Module      : adv7393_axil_csr
// Description : AXI4-Lite slave CSR file holding the ADV7393 encoder
//               configuration. NUM_REGS registers of REG_WIDTH bits at word
//               indices 0..NUM_REGS-1, a CTRL word at index NUM_REGS
//               (bit0 write = commit, bit1 read = pending), everything else
//               unmapped (SLVERR). Per-register update pulses feed the I2C
//               loader.
//               Optional feature macro: ADV7393_CSR_SHADOW_EN
//                 defined   : writes land in a shadow bank, CTRL commit copies
//                             shadow to the active image.
//                 undefined : writes update the active image directly.
// Ports       : clk      - clock
//               reset    - synchronous reset, active-low
//               s_axi    - AXI4-Lite slave (adv7393_axil_csr_if.slave)
//               reg_q    - active register image, reg i at [i*REG_WIDTH +: REG_WIDTH]
//               reg_upd  - one-cycle pulse per register whose active value was written
// Revision    : 1.0 - initial release
// ============================================================================
module adv7393_axil_csr #(
   parameter int                            S_AXI_AWIDTH = 8,
   parameter int                            S_AXI_DWIDTH = 32,
   parameter int                            NUM_REGS     = 16,
   parameter int                            REG_WIDTH    = 8,
   parameter logic [NUM_REGS*REG_WIDTH-1:0] REG_DEFAULT  = '0
) (
   input  wire logic                          clk,
   input  wire logic                          reset,
   adv7393_axil_csr_if.slave                  s_axi,
   output logic [NUM_REGS*REG_WIDTH-1:0]      reg_q,
   output logic [NUM_REGS-1:0]                reg_upd
);

   localparam int                c_IW          = S_AXI_AWIDTH - 2;
   localparam int                c_IMG_W       = NUM_REGS * REG_WIDTH;
   localparam logic [c_IW-1:0]   c_CTRL_IDX    = c_IW'(NUM_REGS);
   localparam logic [1:0]        c_RESP_OKAY   = 2'b00;
   localparam logic [1:0]        c_RESP_SLVERR = 2'b10;

   localparam logic [1:0]        R_IDLE        = 2'd0;
   localparam logic [1:0]        R_DATA        = 2'd1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                      r_aw_held;
   logic [c_IW-1:0]           r_aw_idx;
   logic                      r_w_held;
   logic [S_AXI_DWIDTH-1:0]   r_wdata;
   logic [3:0]                r_wstrb;
   logic                      r_bvalid;
   logic [1:0]                r_bresp;

   logic [1:0]                r_rstate;
   logic [S_AXI_DWIDTH-1:0]   r_rdata;
   logic [1:0]                r_rresp;

   logic [c_IMG_W-1:0]        r_active;
   logic [NUM_REGS-1:0]       r_upd;
`ifdef ADV7393_CSR_SHADOW_EN
   logic [c_IMG_W-1:0]        r_shadow;
`endif

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic [c_IMG_W-1:0]        w_bank;        // bank seen by register writes/reads
   logic [c_IMG_W-1:0]        w_bank_next;
   logic [NUM_REGS-1:0]       w_wr_onehot;
   logic [REG_WIDTH-1:0]      w_mask;
   logic [REG_WIDTH-1:0]      w_wr_old;
   logic [REG_WIDTH-1:0]      w_wr_new;
   logic                      w_exec;
   logic                      w_wr_reg_hit;
   logic                      w_wr_ctrl_hit;
   logic                      w_wr_any_strb;
   logic                      w_pending;
   logic [c_IW-1:0]           w_ar_idx;
   logic [S_AXI_DWIDTH-1:0]   w_rd_data;
   logic [1:0]                w_rd_resp;
   logic                      w_unused_ok;

   // Byte strobe k covers register bits [8k+7:8k]; bits beyond REG_WIDTH never exist.
   for (genvar b = 0; b < REG_WIDTH; b++) begin : g_mask
      assign w_mask[b] = r_wstrb[b/8];
   end

`ifdef ADV7393_CSR_SHADOW_EN
   logic [NUM_REGS-1:0]       w_diff;
   logic                      w_commit;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_diff
      assign w_diff[i] = r_shadow[i*REG_WIDTH +: REG_WIDTH] != r_active[i*REG_WIDTH +: REG_WIDTH];
   end

   assign w_bank    = r_shadow;
   assign w_pending = |w_diff;
   assign w_commit  = w_exec & w_wr_ctrl_hit & r_wstrb[0] & r_wdata[0];
`else
   assign w_bank    = r_active;
   assign w_pending = 1'b0;
`endif

   // Both holds present means the write executes at this edge; holds are
   // only ever loaded while bvalid is low, so no extra qualification needed.
   assign w_exec        = r_aw_held & r_w_held;
   assign w_wr_reg_hit  = r_aw_idx < c_CTRL_IDX;
   assign w_wr_ctrl_hit = r_aw_idx == c_CTRL_IDX;
   assign w_wr_any_strb = |r_wstrb;

   always_comb begin
      w_wr_old = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_aw_idx == c_IW'(i)) begin
            w_wr_old = w_bank[i*REG_WIDTH +: REG_WIDTH];
         end
      end
      w_wr_new = (w_wr_old & ~w_mask) | (r_wdata[REG_WIDTH-1:0] & w_mask);
   end

   // Next bank image with the addressed register merged in. A nonzero
   // strobe counts as a write even if it covers no bit of the register.
   always_comb begin
      w_bank_next = w_bank;
      w_wr_onehot = '0;
      if (w_exec && w_wr_reg_hit && w_wr_any_strb) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_aw_idx == c_IW'(i)) begin
               w_bank_next[i*REG_WIDTH +: REG_WIDTH] = w_wr_new;
               w_wr_onehot[i]                        = 1'b1;
            end
         end
      end
   end

   // Read data is sampled from current state, so a read accepted in the
   // same cycle a write executes returns the pre-write value.
   always_comb begin
      w_ar_idx  = s_axi.araddr[S_AXI_AWIDTH-1:2];
      w_rd_data = '0;
      w_rd_resp = c_RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ar_idx == c_IW'(i)) begin
            w_rd_data[REG_WIDTH-1:0] = w_bank[i*REG_WIDTH +: REG_WIDTH];
            w_rd_resp                = c_RESP_OKAY;
         end
      end
      if (w_ar_idx == c_CTRL_IDX) begin
         w_rd_data[1] = w_pending;
         w_rd_resp    = c_RESP_OKAY;
      end
   end

   // ------------------------------------------------------------------
   // Write path: independent AW/W holds, single outstanding response
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= c_RESP_OKAY;
         r_active  <= REG_DEFAULT;
         r_upd     <= '0;
`ifdef ADV7393_CSR_SHADOW_EN
         r_shadow  <= REG_DEFAULT;
`endif
      end else begin
         if (s_axi.awvalid && s_axi.awready) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi.awaddr[S_AXI_AWIDTH-1:2];
         end
         if (s_axi.wvalid && s_axi.wready) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.wdata;
            r_wstrb  <= s_axi.wstrb;
         end

         if (w_exec) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= (w_wr_reg_hit || w_wr_ctrl_hit) ? c_RESP_OKAY : c_RESP_SLVERR;
         end else if (r_bvalid && s_axi.bready) begin
            r_bvalid  <= 1'b0;
         end

`ifdef ADV7393_CSR_SHADOW_EN
         r_shadow <= w_bank_next;
         if (w_commit) begin
            r_active <= r_shadow;
            r_upd    <= w_diff;
         end else begin
            r_upd    <= '0;
         end
`else
         r_active <= w_bank_next;
         r_upd    <= w_wr_onehot;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Read path FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= c_RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s_axi.arvalid) begin
                  r_rdata  <= w_rd_data;
                  r_rresp  <= w_rd_resp;
                  r_rstate <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Ready signals are gated by reset so they read 0 while the
   // block is held in reset.
   // ------------------------------------------------------------------
   assign s_axi.awready = reset & ~r_aw_held & ~r_bvalid;
   assign s_axi.wready  = reset & ~r_w_held  & ~r_bvalid;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = reset & (r_rstate == R_IDLE);
   assign s_axi.rvalid  = r_rstate == R_DATA;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;

   assign reg_q   = r_active;
   assign reg_upd = r_upd;

   // Protection bits, byte-offset address bits and data bits above
   // REG_WIDTH carry no meaning for this block.
   assign w_unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                          s_axi.araddr[1:0], r_wdata};

endmodule
`default_nettype wire
